// File: rtl/serial_comparator_framed.sv
// Framed serial magnitude comparator: two WIDTH-bit operands arrive DIGIT bits per beat,
// and one registered one-hot verdict is produced per word, qualified by out_valid.
//
// partial | meaning
// --------+---------------------------------------------
// ST_EQ   | all digits seen so far are equal (word start)
// ST_LT   | A < B decided by the digits seen so far
// ST_GT   | A > B decided by the digits seen so far
module serial_comparator_framed #(
    parameter int WIDTH     = 8,
    parameter int DIGIT     = 1,
    parameter int MSB_FIRST = 1,
    parameter int SIGNED    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             busy,
    output logic             out_valid,
    output logic             a_less_b,
    output logic             a_eq_b,
    output logic             a_greater_b,
    output logic             frame_err
);

    localparam int NBEATS = WIDTH / DIGIT;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    localparam logic [CW-1:0]    LAST_BEAT = CW'(NBEATS - 1);
    localparam logic [CW-1:0]    SIGN_BEAT = (MSB_FIRST != 0) ? '0 : LAST_BEAT;
    localparam logic [DIGIT-1:0] SIGN_MASK = DIGIT'(1) << (DIGIT - 1);

    localparam logic [1:0] ST_EQ = 2'd0;
    localparam logic [1:0] ST_LT = 2'd1;
    localparam logic [1:0] ST_GT = 2'd2;

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    beat_idx;
    logic [1:0]       partial;
    logic [1:0]       base;
    logic [1:0]       digit_res;
    logic [1:0]       next_partial;
    logic [DIGIT-1:0] a_eff;
    logic [DIGIT-1:0] b_eff;
    logic             start;
    logic             accept;
    logic             last_beat;
    logic             bad_frame;

    always_comb begin
        start     = in_valid & in_first;
        accept    = in_valid & (in_first | busy);
        // Stray beat while idle, or a restart while a word is in flight.
        bad_frame = in_valid & (in_first == busy);
        beat_idx  = start ? '0 : cnt;

        a_eff = a;
        b_eff = b;
        // Flipping the sign bit of both operands turns the unsigned compare into a signed one.
        if ((SIGNED != 0) && (beat_idx == SIGN_BEAT)) begin
            a_eff = a ^ SIGN_MASK;
            b_eff = b ^ SIGN_MASK;
        end

        if (a_eff < b_eff)
            digit_res = ST_LT;
        else if (a_eff > b_eff)
            digit_res = ST_GT;
        else
            digit_res = ST_EQ;

        base = start ? ST_EQ : partial;

        if (MSB_FIRST != 0)
            next_partial = (base == ST_EQ) ? digit_res : base;
        else
            next_partial = (digit_res != ST_EQ) ? digit_res : base;

        last_beat = accept & (beat_idx == LAST_BEAT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            frame_err   <= 1'b0;
            a_less_b    <= 1'b0;
            a_eq_b      <= 1'b0;
            a_greater_b <= 1'b0;
            cnt         <= '0;
            partial     <= ST_EQ;
        end else begin
            out_valid <= 1'b0;
            frame_err <= bad_frame;
            if (accept) begin
                if (last_beat) begin
                    out_valid   <= 1'b1;
                    a_less_b    <= (next_partial == ST_LT);
                    a_eq_b      <= (next_partial == ST_EQ);
                    a_greater_b <= (next_partial == ST_GT);
                    busy        <= 1'b0;
                    cnt         <= '0;
                    partial     <= ST_EQ;
                end else begin
                    busy    <= 1'b1;
                    cnt     <= beat_idx + CW'(1);
                    partial <= next_partial;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_comparator_framed.sv
// Scoreboard bench for serial_comparator_framed over four digit/order/sign configurations.
module tb_serial_comparator_framed;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    typedef struct {
        int         cyc;
        logic [2:0] v;
    } exp_t;

    // Reference verdict {lt, eq, gt} from whole-word integer arithmetic.
    function automatic logic [2:0] ref_cmp(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input bit sg);
        int ia, ib;
        ia = sg ? int'($signed(av)) : int'(av);
        ib = sg ? int'($signed(bv)) : int'(bv);
        if (ia < ib) return 3'b100;
        if (ia == ib) return 3'b010;
        return 3'b001;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : cfg
        localparam int D  = (g < 2) ? 1 : 2;
        localparam int MF = (g == 1 || g == 3) ? 0 : 1;
        localparam int SG = (g >= 2) ? 1 : 0;
        localparam int NB = W / D;
        localparam logic [15:0] V0 = (g == 0) ? 16'h807F : (g == 1) ? 16'h0180 : 16'hFF01;
        localparam logic [15:0] V1 = (g == 0) ? 16'h5A5A : (g == 1) ? 16'h8001 : 16'h807F;

        logic         rst = 1'b1;
        logic         in_valid = 1'b0;
        logic         in_first = 1'b0;
        logic [D-1:0] a = '0;
        logic [D-1:0] b = '0;
        logic         busy, out_valid, a_less_b, a_eq_b, a_greater_b, frame_err;

        exp_t exp_q[$];
        int   ferr_q[$];
        int   last_cyc;
        int   first_cyc;

        serial_comparator_framed #(
            .WIDTH(W), .DIGIT(D), .MSB_FIRST(MF), .SIGNED(SG)
        ) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
            .a(a), .b(b), .busy(busy), .out_valid(out_valid),
            .a_less_b(a_less_b), .a_eq_b(a_eq_b), .a_greater_b(a_greater_b),
            .frame_err(frame_err)
        );

        function automatic logic [D-1:0] dig(input logic [W-1:0] v, input int i);
            int pos;
            pos = (MF != 0) ? (NB - 1 - i) : i;
            return v[pos*D +: D];
        endfunction

        task automatic beat(input logic f, input logic [D-1:0] da, input logic [D-1:0] db);
            @(posedge clk); #1;
            in_valid = 1'b1; in_first = f; a = da; b = db;
            last_cyc = cyc;
        endtask

        task automatic bubble(input int n);
            repeat (n) begin
                @(posedge clk); #1;
                in_valid = 1'b0; in_first = 1'($urandom);
                a = D'($urandom); b = D'($urandom);
            end
        endtask

        // Sends the first nb beats of a word; a complete word queues its verdict.
        task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input int gap_pct,
                            input int nb, input bit restart);
            for (int i = 0; i < nb; i++) begin
                if (i > 0 && $urandom_range(99) < gap_pct) bubble($urandom_range(3, 1));
                beat(i == 0, dig(av, i), dig(bv, i));
                if (i == 0) begin
                    first_cyc = last_cyc;
                    if (restart) ferr_q.push_back(first_cyc + 1);
                end
            end
            if (nb == NB) exp_q.push_back('{last_cyc + 1, ref_cmp(av, bv, SG != 0)});
        endtask

        always @(negedge clk) begin : mon
            exp_t e;
            int   fc;
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL cfg%0d verdict: unexpected out_valid at cycle %0d", g, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || {a_less_b, a_eq_b, a_greater_b} != e.v) begin
                        errors++;
                        $display("FAIL cfg%0d verdict: got lt/eq/gt=%b at cycle %0d, want %b at cycle %0d",
                                 g, {a_less_b, a_eq_b, a_greater_b}, cyc, e.v, e.cyc);
                    end
                end
            end
            if (frame_err) begin
                checks++;
                if (ferr_q.size() == 0) begin
                    errors++;
                    $display("FAIL cfg%0d frame_err: unexpected pulse at cycle %0d", g, cyc);
                end else begin
                    fc = ferr_q.pop_front();
                    if (cyc != fc) begin
                        errors++;
                        $display("FAIL cfg%0d frame_err: pulse at cycle %0d, want cycle %0d", g, cyc, fc);
                    end
                end
            end
        end

        initial begin : drv
            logic [W-1:0] ra, rb;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            checks++;
            if ({busy, out_valid, a_less_b, a_eq_b, a_greater_b, frame_err} != 6'b0) begin
                errors++;
                $display("FAIL cfg%0d reset_state: outputs=%b, want 000000", g,
                         {busy, out_valid, a_less_b, a_eq_b, a_greater_b, frame_err});
            end

            send(V0[15:8], V0[7:0], 0, NB, 1'b0);
            bubble(2);
            send(V1[15:8], V1[7:0], 0, NB, 1'b0);
            bubble(1);

            // Back-to-back words: LT then GT with no idle cycle between.
            send(8'h10, 8'h20, 0, NB, 1'b0);
            send(8'h30, 8'h20, 0, NB, 1'b0);
            bubble(1);

            for (int k = 0; k < 12; k++) begin
                ra = W'($urandom);
                rb = ($urandom_range(3) == 0) ? ra : W'($urandom);
                send(ra, rb, 40, NB, 1'b0);
                if ($urandom_range(1) == 1) bubble($urandom_range(2, 1));
            end
            bubble(1);

            // Restart mid-word: aborted word yields nothing, restarted word is judged.
            send(8'hC3, 8'h3C, 0, (NB > 4) ? 3 : 2, 1'b0);
            send(8'h12, 8'h34, 0, NB, 1'b1);
            bubble(2);

            // Stray beat while idle is dropped and flagged.
            beat(1'b0, D'($urandom), D'($urandom));
            ferr_q.push_back(last_cyc + 1);
            bubble(1);
            send(8'h44, 8'h43, 0, NB, 1'b0);
            bubble(2);

            // Reset in the middle of a word.
            send(8'h77, 8'h11, 0, NB / 2, 1'b0);
            @(posedge clk); #1;
            checks++;
            if (busy != 1'b1) begin
                errors++;
                $display("FAIL cfg%0d busy_mid_word: busy=%b, want 1", g, busy);
            end
            rst = 1'b1; in_valid = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            checks++;
            if ({busy, out_valid, a_less_b, a_eq_b, a_greater_b, frame_err} != 6'b0) begin
                errors++;
                $display("FAIL cfg%0d mid_word_reset: outputs=%b, want 000000", g,
                         {busy, out_valid, a_less_b, a_eq_b, a_greater_b, frame_err});
            end
            send(8'h03, 8'h03, 0, NB, 1'b0);
            bubble(4);

            checks++;
            if (exp_q.size() != 0 || ferr_q.size() != 0) begin
                errors++;
                $display("FAIL cfg%0d drain: %0d verdicts and %0d frame_err pulses outstanding, want 0 and 0",
                         g, exp_q.size(), ferr_q.size());
            end
            done_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 20000 && done_cnt < 4; i++) @(posedge clk);
        if (done_cnt < 4) begin
            errors++;
            $display("FAIL timeout: %0d of 4 configurations finished, want 4", done_cnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_comparator_framed.md
Name: serial_comparator_framed

Overview:
Parametrised, framed serial magnitude comparator. Accepts two operands of WIDTH bits streamed DIGIT bits per beat, in either MSB-first or LSB-first order, with unsigned or two's-complement interpretation. Produces one registered, one-hot verdict per word, qualified by a single-cycle out_valid pulse. It replaces the fixed 1-bit, unframed serial comparators in the sequential-basics library wherever words arrive back to back on a serial link.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 1 and divisible by DIGIT.
- DIGIT, 1, bits of each operand presented per beat; NBEATS = WIDTH/DIGIT.
- MSB_FIRST, 1, 1 = most significant digit first, 0 = least significant digit first.
- SIGNED, 0, 1 = operands are two's complement, 0 = unsigned.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  beat qualifier; a, b, in_first ignored when low
- in_first  input  1  marks beat 0 of a word
- a  input  DIGIT  current digit of operand A
- b  input  DIGIT  current digit of operand B
- busy  output  1  word in progress (beats 1..NBEATS-1 expected)
- out_valid  output  1  one-cycle pulse: verdict outputs updated this cycle
- a_less_b  output  1  registered verdict A < B
- a_eq_b  output  1  registered verdict A == B
- a_greater_b  output  1  registered verdict A > B
- frame_err  output  1  one-cycle pulse on framing violation

Behaviour:
- Reset: busy=0, out_valid=0, frame_err=0, all three verdicts=0, beat counter=0, internal partial state = EQ.
- Partial state: 2-bit encoded {EQ, LT, GT}. Digit compare is an unsigned D-bit compare of a vs b, giving a digit result of EQ/LT/GT.
- Signed mode: the operand MSB (bit DIGIT-1 of beat 0 when MSB_FIRST=1, of beat NBEATS-1 when MSB_FIRST=0) is inverted in both a and b before the digit compare. Unsigned compare of sign-flipped values equals signed compare.
- MSB_FIRST=1 update: if partial==EQ, partial <= digit result; otherwise partial is held (first differing digit decides).
- MSB_FIRST=0 update: if digit result != EQ, partial <= digit result; otherwise partial is held (last differing digit decides).
- Beat 0 combines with a fresh EQ state; the previous word's state never leaks into the next word.
- Idle (busy=0):
  - in_valid & in_first starts a word. If NBEATS==1 it completes immediately; otherwise busy<=1 and the counter is set to 1.
  - in_valid & ~in_first drops the beat and pulses frame_err next cycle; state is unchanged.
- Busy:
  - in_valid & ~in_first accepts the beat and increments the counter.
  - A beat with in_first mid-word aborts the current word (no out_valid) and pulses frame_err. That beat is taken as beat 0 of a new word.
- Completion: on the cycle the last beat (index NBEATS-1) is accepted, the next edge performs all of the following:
  - sets out_valid=1;
  - loads exactly one verdict from the final partial state;
  - clears busy and the counter.
- Latency from last beat to verdict: 1 clock.
- Back-to-back words with no idle cycle are supported at full rate (one beat per clock).
- Verdict outputs hold their value until the next completion. out_valid and frame_err are high for exactly one cycle each.
- in_valid low: bubble; counter, partial state and busy are held indefinitely.
- Reset mid-word: the word is discarded with no out_valid and no frame_err; state returns to reset values on the next edge.
- Counter width is clog2(NBEATS) with a minimum of 1; the counter never exceeds NBEATS-1.

Test Plan:
- WIDTH=8, DIGIT=1, MSB_FIRST=1, unsigned: A=0x80, B=0x7F, 8 contiguous beats -> out_valid one cycle after beat 7, a_greater_b=1, other verdicts 0; A=B=0x5A -> a_eq_b=1.
- WIDTH=8, DIGIT=1, MSB_FIRST=0, unsigned: A=0x01, B=0x80 -> a_less_b=1, confirming the last-significant digit overrides the earlier greater digit.
- WIDTH=8, DIGIT=2, SIGNED=1, both orders: A=0xFF (-1), B=0x01 -> a_less_b=1; A=0x80 (-128), B=0x7F -> a_less_b=1; each word spans 4 beats.
- Bubbles and back-to-back words: random in_valid gaps inside a word give the same verdict as gap-free input; two consecutive words A<B then A>B with no idle cycle -> two out_valid pulses exactly 4 clocks apart (WIDTH=8, DIGIT=2), verdicts LT then GT.
- Framing: in_first reasserted at beat 3 of 8 -> frame_err pulse, no out_valid for the aborted word, and a correct verdict for the restarted word. A beat without in_first while idle -> frame_err pulse and the beat is ignored.
- Reset at beat 4 of 8, then a fresh word A=3, B=3 -> no stale out_valid, a_eq_b=1 after the fresh word; all outputs 0 immediately after reset.
